// File: rtl/point_scheduler.sv
// Point scheduler: walks every stored car mass point through the collision
// stage once per physics frame, writing the returned position/velocity back.
// Also provides a registered position readout for the renderer.
module point_scheduler #(
  parameter int NUM_POINTS        = 4,
  parameter int POSITION_SIZE     = 8,
  parameter int VELOCITY_SIZE     = 8,
  parameter int ACCELERATION_SIZE = 8,
  parameter int GRAVITY_Y         = -1,
  parameter int TIMEOUT           = 255
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                frame_in,
  input  logic                                load_in,
  input  logic [3:0]                          load_idx_in,
  input  logic signed [POSITION_SIZE-1:0]     load_pos_x_in,
  input  logic signed [POSITION_SIZE-1:0]     load_pos_y_in,
  input  logic signed [VELOCITY_SIZE-1:0]     load_vel_x_in,
  input  logic signed [VELOCITY_SIZE-1:0]     load_vel_y_in,
  output logic                                begin_out,
  output logic signed [POSITION_SIZE-1:0]     pos_x_out,
  output logic signed [POSITION_SIZE-1:0]     pos_y_out,
  output logic signed [VELOCITY_SIZE-1:0]     vel_x_out,
  output logic signed [VELOCITY_SIZE-1:0]     vel_y_out,
  output logic signed [ACCELERATION_SIZE-1:0] accel_x_out,
  output logic signed [ACCELERATION_SIZE-1:0] accel_y_out,
  input  logic                                result_in,
  input  logic signed [POSITION_SIZE-1:0]     new_pos_x_in,
  input  logic signed [POSITION_SIZE-1:0]     new_pos_y_in,
  input  logic signed [VELOCITY_SIZE-1:0]     new_vel_x_in,
  input  logic signed [VELOCITY_SIZE-1:0]     new_vel_y_in,
  input  logic [3:0]                          rd_idx_in,
  output logic signed [POSITION_SIZE-1:0]     rd_pos_x_out,
  output logic signed [POSITION_SIZE-1:0]     rd_pos_y_out,
  output logic                                busy_out,
  output logic                                frame_done_out,
  output logic                                timeout_out
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [4:0] NP5 = 5'(NUM_POINTS);
  localparam logic [3:0] LAST_IDX = 4'(NUM_POINTS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic signed [ACCELERATION_SIZE-1:0] GRAV = ACCELERATION_SIZE'(GRAVITY_Y);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t state_q;
  logic [3:0]    idx_q;
  logic [CW-1:0] cnt_q;

  // Storage is 16 deep so a 4-bit index never reads out of range; entries at
  // or above NUM_POINTS are never written and stay at their reset value.
  logic signed [POSITION_SIZE-1:0] px_q [16];
  logic signed [POSITION_SIZE-1:0] py_q [16];
  logic signed [VELOCITY_SIZE-1:0] vx_q [16];
  logic signed [VELOCITY_SIZE-1:0] vy_q [16];

  logic begin_q, busy_q, done_q, timeout_q;
  logic signed [POSITION_SIZE-1:0] op_px_q, op_py_q, rd_x_q, rd_y_q;
  logic signed [VELOCITY_SIZE-1:0] op_vx_q, op_vy_q;
  logic signed [ACCELERATION_SIZE-1:0] acc_y_q;

  logic       load_ok_s, rd_ok_s;
  logic [3:0] nxt_idx_d;
  logic signed [POSITION_SIZE-1:0] op_px_d, op_py_d;
  logic signed [VELOCITY_SIZE-1:0] op_vx_d, op_vy_d;

  assign load_ok_s = load_in && ({1'b0, load_idx_in} < NP5);
  assign rd_ok_s   = ({1'b0, rd_idx_in} < NP5);

  // Operands for the next issued point; a same-cycle load in IDLE is forwarded
  // so the frame sees the freshly loaded value.
  always_comb begin
    nxt_idx_d = (state_q == S_IDLE) ? 4'd0 : idx_q + 4'd1;
    if ((state_q == S_IDLE) && load_ok_s && (load_idx_in == nxt_idx_d)) begin
      op_px_d = load_pos_x_in;
      op_py_d = load_pos_y_in;
      op_vx_d = load_vel_x_in;
      op_vy_d = load_vel_y_in;
    end else begin
      op_px_d = px_q[nxt_idx_d];
      op_py_d = py_q[nxt_idx_d];
      op_vx_d = vx_q[nxt_idx_d];
      op_vy_d = vy_q[nxt_idx_d];
    end
  end

  // Frame FSM, point storage, registered operands/status and readout.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      cnt_q     <= '0;
      begin_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      op_px_q   <= '0;
      op_py_q   <= '0;
      op_vx_q   <= '0;
      op_vy_q   <= '0;
      acc_y_q   <= '0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      for (int i = 0; i < 16; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      begin_q <= 1'b0;
      done_q  <= 1'b0;
      rd_x_q  <= rd_ok_s ? px_q[rd_idx_in] : '0;
      rd_y_q  <= rd_ok_s ? py_q[rd_idx_in] : '0;
      case (state_q)
        S_IDLE: begin
          if (load_ok_s) begin
            px_q[load_idx_in] <= load_pos_x_in;
            py_q[load_idx_in] <= load_pos_y_in;
            vx_q[load_idx_in] <= load_vel_x_in;
            vy_q[load_idx_in] <= load_vel_y_in;
          end
          if (frame_in) begin
            idx_q   <= 4'd0;
            state_q <= S_ISSUE;
            busy_q  <= 1'b1;
            begin_q <= 1'b1;
            op_px_q <= op_px_d;
            op_py_q <= op_py_d;
            op_vx_q <= op_vx_d;
            op_vy_q <= op_vy_d;
            acc_y_q <= GRAV;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (result_in) begin
            px_q[idx_q] <= new_pos_x_in;
            py_q[idx_q] <= new_pos_y_in;
            vx_q[idx_q] <= new_vel_x_in;
            vy_q[idx_q] <= new_vel_y_in;
            state_q     <= S_WRITE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= S_WRITE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WRITE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= nxt_idx_d;
            state_q <= S_ISSUE;
            begin_q <= 1'b1;
            op_px_q <= op_px_d;
            op_py_q <= op_py_d;
            op_vx_q <= op_vx_d;
            op_vy_q <= op_vy_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign begin_out      = begin_q;
  assign pos_x_out      = op_px_q;
  assign pos_y_out      = op_py_q;
  assign vel_x_out      = op_vx_q;
  assign vel_y_out      = op_vy_q;
  assign accel_x_out    = '0;
  assign accel_y_out    = acc_y_q;
  assign rd_pos_x_out   = rd_x_q;
  assign rd_pos_y_out   = rd_y_q;
  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign timeout_out    = timeout_q;

endmodule

// File: tb/tb_point_scheduler.sv
// Bench for point_scheduler: table of load/readback vectors, then frames
// driven by a modelled collision stage with random latencies and results.
module tb_point_scheduler;

  localparam int NP = 4;
  localparam int TO = 8;

  logic clk_in = 1'b0;
  logic rst_in, frame_in, load_in, result_in;
  logic [3:0] load_idx_in, rd_idx_in;
  logic signed [7:0] load_pos_x_in, load_pos_y_in, load_vel_x_in, load_vel_y_in;
  logic signed [7:0] new_pos_x_in, new_pos_y_in, new_vel_x_in, new_vel_y_in;
  logic begin_out, busy_out, frame_done_out, timeout_out;
  logic signed [7:0] pos_x_out, pos_y_out, vel_x_out, vel_y_out;
  logic signed [7:0] accel_x_out, accel_y_out, rd_pos_x_out, rd_pos_y_out;

  point_scheduler #(.NUM_POINTS(NP), .POSITION_SIZE(8), .VELOCITY_SIZE(8),
                    .ACCELERATION_SIZE(8), .GRAVITY_Y(-1), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_in(frame_in), .load_in(load_in),
    .load_idx_in(load_idx_in), .load_pos_x_in(load_pos_x_in), .load_pos_y_in(load_pos_y_in),
    .load_vel_x_in(load_vel_x_in), .load_vel_y_in(load_vel_y_in), .begin_out(begin_out),
    .pos_x_out(pos_x_out), .pos_y_out(pos_y_out), .vel_x_out(vel_x_out), .vel_y_out(vel_y_out),
    .accel_x_out(accel_x_out), .accel_y_out(accel_y_out), .result_in(result_in),
    .new_pos_x_in(new_pos_x_in), .new_pos_y_in(new_pos_y_in), .new_vel_x_in(new_vel_x_in),
    .new_vel_y_in(new_vel_y_in), .rd_idx_in(rd_idx_in), .rd_pos_x_out(rd_pos_x_out),
    .rd_pos_y_out(rd_pos_y_out), .busy_out(busy_out), .frame_done_out(frame_done_out),
    .timeout_out(timeout_out));

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: point state, planned collision results and latencies
  // (-1 latency = never answer).
  int mx [NP], my [NP], mvx [NP], mvy [NP];
  int rx [NP], ry [NP], rvx [NP], rvy [NP];
  int dly [NP];

  typedef struct {
    int idx; int px; int py; int vx; int vy;
    int rd;  int ex; int ey;
  } vec_t;
  vec_t tbl [6];

  function automatic int s8(input int v);
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic load_pt(input int idx, input int px, input int py, input int vx, input int vy);
    load_in = 1'b1; load_idx_in = 4'(idx);
    load_pos_x_in = 8'(px); load_pos_y_in = 8'(py);
    load_vel_x_in = 8'(vx); load_vel_y_in = 8'(vy);
    step();
    load_in = 1'b0;
    if (idx < NP) begin
      mx[idx] = s8(px); my[idx] = s8(py); mvx[idx] = s8(vx); mvy[idx] = s8(vy);
    end
  endtask

  task automatic rd_chk(input int idx);
    rd_idx_in = 4'(idx);
    step();
    chk("rd_pos_x", int'(rd_pos_x_out), (idx < NP) ? mx[idx] : 0);
    chk("rd_pos_y", int'(rd_pos_y_out), (idx < NP) ? my[idx] : 0);
  endtask

  task automatic randomize_results();
    for (int p = 0; p < NP; p++) begin
      rx[p] = s8(int'($urandom)); ry[p] = s8(int'($urandom));
      rvx[p] = s8(int'($urandom)); rvy[p] = s8(int'($urandom));
    end
  endtask

  // Runs one frame acting as the collision stage. inject pulses frame_in and
  // a load during point 1's WAIT; co_load loads point 0 alongside frame_in.
  task automatic run_frame(input bit inject, input bit co_load, input bit chk_lat);
    int n;
    int exp_lat;
    exp_lat = 3 * NP + 1;
    for (int p = 0; p < NP; p++) exp_lat += (dly[p] > 0) ? dly[p] : 0;
    if (co_load) begin
      load_in = 1'b1; load_idx_in = 4'd0;
      mx[0] = s8(int'($urandom)); my[0] = s8(int'($urandom));
      mvx[0] = s8(int'($urandom)); mvy[0] = s8(int'($urandom));
      load_pos_x_in = 8'(mx[0]); load_pos_y_in = 8'(my[0]);
      load_vel_x_in = 8'(mvx[0]); load_vel_y_in = 8'(mvy[0]);
    end
    frame_in = 1'b1;
    cyc = 0;
    step();
    frame_in = 1'b0; load_in = 1'b0;
    for (int p = 0; p < NP; p++) begin
      n = 0;
      while (!begin_out && n < 40) begin step(); n++; end
      chk("begin_seen", int'(begin_out), 1);
      chk("op_pos_x", int'(pos_x_out), mx[p]);
      chk("op_pos_y", int'(pos_y_out), my[p]);
      chk("op_vel_x", int'(vel_x_out), mvx[p]);
      chk("op_vel_y", int'(vel_y_out), mvy[p]);
      chk("accel_x", int'(accel_x_out), 0);
      chk("accel_y", int'(accel_y_out), -1);
      chk("busy_in_frame", int'(busy_out), 1);
      step();
      chk("begin_one_cycle", int'(begin_out), 0);
      if (dly[p] >= 0) begin
        for (int k = 0; k < dly[p]; k++) begin
          if (inject && p == 1 && k == 0) begin
            frame_in = 1'b1; load_in = 1'b1; load_idx_in = 4'd3;
            load_pos_x_in = 8'sd99; load_pos_y_in = 8'sd99;
            load_vel_x_in = 8'sd99; load_vel_y_in = 8'sd99;
          end
          step();
          frame_in = 1'b0; load_in = 1'b0;
        end
        chk("op_stable_wait", int'(pos_y_out), my[p]);
        result_in = 1'b1;
        new_pos_x_in = 8'(rx[p]); new_pos_y_in = 8'(ry[p]);
        new_vel_x_in = 8'(rvx[p]); new_vel_y_in = 8'(rvy[p]);
        step();
        result_in = 1'b0;
        mx[p] = rx[p]; my[p] = ry[p]; mvx[p] = rvx[p]; mvy[p] = rvy[p];
      end
    end
    n = 0;
    while (!frame_done_out && n < 40) begin step(); n++; end
    chk("frame_done", int'(frame_done_out), 1);
    if (chk_lat) chk("frame_latency", cyc, exp_lat);
    step();
    chk("done_one_cycle", int'(frame_done_out), 0);
    chk("idle_after_frame", int'(busy_out), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_extra_begin", int'(begin_out | frame_done_out), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; frame_in = 1'b0; load_in = 1'b0; result_in = 1'b0;
    load_idx_in = 4'd0; rd_idx_in = 4'd0;
    load_pos_x_in = '0; load_pos_y_in = '0; load_vel_x_in = '0; load_vel_y_in = '0;
    new_pos_x_in = '0; new_pos_y_in = '0; new_vel_x_in = '0; new_vel_y_in = '0;
    for (int p = 0; p < NP; p++) begin
      mx[p] = 0; my[p] = 0; mvx[p] = 0; mvy[p] = 0; dly[p] = 0;
    end
    tbl[0] = '{0, -4, -7, 6, 1, 0, -4, -7};
    tbl[1] = '{1, 10, 20, -3, 2, 1, 10, 20};
    tbl[2] = '{2, -128, 127, 5, -5, 2, -128, 127};
    tbl[3] = '{3, 33, -44, 0, 7, 3, 33, -44};
    tbl[4] = '{5, 9, 9, 1, 1, 5, 0, 0};
    tbl[5] = '{15, 1, 1, 1, 1, 0, -4, -7};
    step(); step();
    rst_in = 1'b0;
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_begin", int'(begin_out), 0);
    chk("rst_done", int'(frame_done_out), 0);
    chk("rst_timeout", int'(timeout_out), 0);
    chk("rst_accel_y", int'(accel_y_out), 0);
    chk("rst_rd_x", int'(rd_pos_x_out), 0);

    // Loads (including out-of-range indices) followed by registered readback.
    for (int i = 0; i < 6; i++) begin
      load_pt(tbl[i].idx, tbl[i].px, tbl[i].py, tbl[i].vx, tbl[i].vy);
      rd_idx_in = 4'(tbl[i].rd);
      step();
      chk("tbl_rd_x", int'(rd_pos_x_out), tbl[i].ex);
      chk("tbl_rd_y", int'(rd_pos_y_out), tbl[i].ey);
    end

    // Point 0 answered two cycles after its begin pulse with (2,-7,6,0).
    randomize_results();
    rx[0] = 2; ry[0] = -7; rvx[0] = 6; rvy[0] = 0;
    dly[0] = 1; dly[1] = 0; dly[2] = 0; dly[3] = 0;
    run_frame(1'b0, 1'b0, 1'b1);
    rd_idx_in = 4'd0; step();
    chk("p0_rd_x", int'(rd_pos_x_out), 2);
    chk("p0_rd_y", int'(rd_pos_y_out), -7);

    // Immediate results: 13-cycle frame.
    randomize_results();
    for (int p = 0; p < NP; p++) dly[p] = 0;
    run_frame(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < NP; i++) rd_chk(i);

    // Random latencies and results, plus a co-issued load of point 0.
    for (int f = 0; f < 4; f++) begin
      randomize_results();
      for (int p = 0; p < NP; p++) dly[p] = int'($urandom_range(0, 3));
      run_frame(1'b0, (f == 1), 1'b1);
      for (int i = 0; i < NP; i++) rd_chk(i);
    end

    // Point 1 never answered: timeout sticks, others still processed.
    randomize_results();
    dly[0] = 0; dly[1] = -1; dly[2] = 1; dly[3] = 0;
    run_frame(1'b0, 1'b0, 1'b0);
    chk("timeout_set", int'(timeout_out), 1);
    for (int i = 0; i < NP; i++) rd_chk(i);
    randomize_results();
    for (int p = 0; p < NP; p++) dly[p] = 0;
    run_frame(1'b0, 1'b0, 1'b1);
    chk("timeout_sticky", int'(timeout_out), 1);

    // frame_in and load_in while busy are dropped.
    randomize_results();
    dly[0] = 0; dly[1] = 2; dly[2] = 0; dly[3] = 0;
    run_frame(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < NP; i++) rd_chk(i);

    // Reset in point 2's WAIT, then a late result.
    randomize_results();
    frame_in = 1'b1; step(); frame_in = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int n = 0; n < 40 && !begin_out; n++) step();
      chk("rst_seq_begin", int'(begin_out), 1);
      chk("rst_seq_op_x", int'(pos_x_out), mx[p]);
      step();
      if (p < 2) begin
        result_in = 1'b1;
        new_pos_x_in = 8'(rx[p]); new_pos_y_in = 8'(ry[p]);
        new_vel_x_in = 8'(rvx[p]); new_vel_y_in = 8'(rvy[p]);
        step();
        result_in = 1'b0;
      end
    end
    rst_in = 1'b1; step(); rst_in = 1'b0;
    for (int p = 0; p < NP; p++) begin mx[p] = 0; my[p] = 0; mvx[p] = 0; mvy[p] = 0; end
    chk("midrst_busy", int'(busy_out), 0);
    chk("midrst_timeout", int'(timeout_out), 0);
    chk("midrst_pos_x", int'(pos_x_out), 0);
    chk("midrst_accel_y", int'(accel_y_out), 0);
    result_in = 1'b1; new_pos_x_in = 8'sd55; new_pos_y_in = 8'sd55;
    step(); result_in = 1'b0;
    chk("midrst_no_begin", int'(begin_out | busy_out), 0);
    for (int i = 0; i < NP; i++) rd_chk(i);

    // Random loads and reads, including out-of-range indices.
    for (int i = 0; i < 20; i++) begin
      load_pt(int'($urandom_range(0, 7)), int'($urandom), int'($urandom),
              int'($urandom), int'($urandom));
      rd_chk(int'($urandom_range(0, 15)));
    end
    rd_chk(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/point_scheduler.md
POINT_SCHEDULER -- requirements
Module: point_scheduler

Interface
REQ-001 Parameter NUM_POINTS, 4, number of car mass points held (1..16).
REQ-002 Parameter POSITION_SIZE, 8, signed position width.
REQ-003 Parameter VELOCITY_SIZE, 8, signed velocity width.
REQ-004 Parameter ACCELERATION_SIZE, 8, signed acceleration width.
REQ-005 Parameter GRAVITY_Y, -1, signed y acceleration applied to every point; x acceleration is 0.
REQ-006 Parameter TIMEOUT, 255, max cycles waited for result_in per point.
REQ-007 One clock; reset is synchronous and active-high; ports: clk_in input 1 system clock; rst_in input 1 synchronous active-high reset.
REQ-008 frame_in input 1: one-cycle pulse starting a physics frame.
REQ-009 load_in input 1; load_idx_in input 4; load_pos_x_in, load_pos_y_in input POSITION_SIZE; load_vel_x_in, load_vel_y_in input VELOCITY_SIZE: writes one point's state.
REQ-010 begin_out output 1: one-cycle start pulse to the collision stage.
REQ-011 pos_x_out, pos_y_out output POSITION_SIZE; vel_x_out, vel_y_out output VELOCITY_SIZE; accel_x_out, accel_y_out output ACCELERATION_SIZE: operands to the collision stage.
REQ-012 result_in input 1; new_pos_x_in, new_pos_y_in input POSITION_SIZE; new_vel_x_in, new_vel_y_in input VELOCITY_SIZE: collision stage results, valid while result_in=1.
REQ-013 rd_idx_in input 4; rd_pos_x_out, rd_pos_y_out output POSITION_SIZE: registered readout for rendering.
REQ-014 busy_out output 1; frame_done_out output 1 (one-cycle pulse); timeout_out output 1 (sticky).

Function
REQ-015 States: IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-016 IDLE: frame_in=1 -> point index cleared to 0, go ISSUE; busy_out=1 in every state except IDLE.
REQ-017 ISSUE: drive point[idx] onto pos/vel outputs, accel_x_out=0, accel_y_out=GRAVITY_Y, begin_out=1 for exactly this cycle, clear wait counter, go WAIT.
REQ-018 Operand outputs hold stable from ISSUE until leaving WAIT.
REQ-019 WAIT: result_in=1 -> capture new_* into point[idx], go WRITE; result_in sampled in the ISSUE cycle is ignored.
REQ-020 WAIT: counter reaches TIMEOUT with no result_in -> point[idx] unchanged, timeout_out set, go WRITE.
REQ-021 WRITE: idx==NUM_POINTS-1 -> go DONE; else idx+1, go ISSUE.
REQ-022 DONE: frame_done_out=1 for one cycle, go IDLE; frame latency with zero-delay results is 3*NUM_POINTS+1 cycles from frame_in to frame_done_out.
REQ-023 frame_in while busy_out=1 is ignored (not queued).
REQ-024 load_in applies only in IDLE; load_in while busy is dropped; load_idx_in >= NUM_POINTS is ignored.
REQ-025 frame_in and load_in in same IDLE cycle: load is written first, frame uses loaded value.
REQ-026 rd_pos_*_out = point[rd_idx_in] registered one cycle; rd_idx_in >= NUM_POINTS returns 0.
REQ-027 Results stored verbatim; no saturation or width change in this block.

Reset
REQ-028 rst_in=1 at any clock edge, including mid-frame: state IDLE, idx 0, all point state 0, all outputs 0, timeout_out cleared; any in-flight result_in is discarded.

Verification
REQ-029 Load point0 (-4,-7,v 6,1), NUM_POINTS=1, frame_in, result returned 2 cycles after begin_out with (2,-7,6,0) -> begin_out once, accel_y_out=-1, rd point0=(2,-7), frame_done_out pulses.
REQ-030 NUM_POINTS=4, immediate results -> exactly 4 begin_out pulses with idx order 0..3, frame_done_out 13 cycles after frame_in.
REQ-031 TIMEOUT=8, result_in never asserted for point1 -> point1 unchanged, timeout_out=1 and stays set, remaining points processed, frame completes.
REQ-032 frame_in and load_in pulsed during WAIT -> no second frame, loaded point unchanged, single frame_done_out.
REQ-033 rst_in asserted in WAIT of point2 -> next cycle busy_out=0, all rd positions 0, late result_in has no effect.
REQ-034 rd_idx_in=5 with NUM_POINTS=4 -> rd_pos outputs 0 one cycle later.
